alu_sequencer: RTL and testbench

//  Issue-side partner of the combinational ALU: accepts 32-bit instruction words over valid/ready, decodes

---
 rtl/alu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Issue-side partner of the combinational ALU. Accepts 32-bit
//               instruction words over valid/ready, reads operands from an
//               internal register bank, presents opcode/operands to the ALU,
//               latches result and C/S/O/Z, then writes back, updates the flag
//               register and computes the next PC (including conditional
//               jumps on the registered flags). One instruction per 4 cycles.
// Ports       : clk, reset (sync, active-high)
//               instr_valid/instr_ready/instr   instruction handshake
//                 instr[31:27] opcode, [26:23] rd, [22:19] ra, [18:15] rb,
//                 [14:0] imm
//               alu_opcode/alu_a/alu_b          to ALU (NOP/0 outside EXEC)
//               alu_resultado, alu_C/S/O/Z      from ALU
//               pc, flags {C,S,O,Z}, halted, illegal (sticky)
//               dbg_addr/dbg_data               combinational bank read
// Options     : ALU_SEQ_LDI_EN - when defined, OP_LD loads the zero-extended
//               immediate into rf[rd]; otherwise OP_LD is unsupported.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int BITS_DATA = 32,
  parameter int NUM_REGS  = 16,
  parameter int PC_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  output logic [4:0]           alu_opcode,
  output logic [BITS_DATA-1:0] alu_a,
  output logic [BITS_DATA-1:0] alu_b,
  input  logic [BITS_DATA-1:0] alu_resultado,
  input  logic                 alu_C,
  input  logic                 alu_S,
  input  logic                 alu_O,
  input  logic                 alu_Z,
  output logic [PC_BITS-1:0]   pc,
  output logic [3:0]           flags,
  output logic                 halted,
  output logic                 illegal,
  input  logic [3:0]           dbg_addr,
  output logic [BITS_DATA-1:0] dbg_data
);

  // Opcode encoding shared with the companion ALU (OP_* set).
  localparam logic [4:0] OP_NOP = 5'd0,  OP_NOT = 5'd1,  OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3,  OP_XOR = 5'd4,  OP_NEG = 5'd5;
  localparam logic [4:0] OP_ADD = 5'd6,  OP_SUB = 5'd7,  OP_MUL = 5'd8;
  localparam logic [4:0] OP_DIV = 5'd9,  OP_MOD = 5'd10, OP_LD  = 5'd11;
  localparam logic [4:0] OP_STR = 5'd12, OP_JMP = 5'd13, OP_JC  = 5'd14;
  localparam logic [4:0] OP_JS  = 5'd15, OP_JO  = 5'd16, OP_JZ  = 5'd17;
  localparam logic [4:0] OP_HLT = 5'd18;

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic [BITS_DATA-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [3:0]           aflags_q, aflags_d;   // ALU flags captured in EXEC
  logic [PC_BITS-1:0]   pc_q, pc_d;
  logic [3:0]           flags_q, flags_d;
  logic                 halted_q, halted_d, illegal_q, illegal_d;
  logic [BITS_DATA-1:0] rf_q [NUM_REGS];
  logic [BITS_DATA-1:0] rf_d [NUM_REGS];

  logic [4:0]           op;
  logic [IDX_W-1:0]     rd_idx, ra_idx, rb_idx;
  logic [PC_BITS-1:0]   pc_inc, pc_imm;
  logic                 is_alu;
  logic                 unused_imm;

  assign op     = instr_q[31:27];
  assign rd_idx = IDX_W'(instr_q[26:23]);
  assign ra_idx = IDX_W'(instr_q[22:19]);
  assign rb_idx = IDX_W'(instr_q[18:15]);
  assign pc_inc = pc_q + PC_BITS'(1);
  assign pc_imm = instr_q[PC_BITS-1:0];
  // Upper immediate bits only matter for LD; keep them visibly consumed.
  assign unused_imm = ^instr_q[14:0];

  // Opcodes whose ALU outputs are meaningful; nothing else is ever latched.
  assign is_alu = (op == OP_NOT) || (op == OP_AND) || (op == OP_OR) ||
                  (op == OP_NEG) || (op == OP_ADD) || (op == OP_SUB) ||
                  (op == OP_MUL);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    aflags_d    = aflags_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    rf_d        = rf_q;
    instr_ready = 1'b0;
    alu_opcode  = OP_NOP;
    alu_a       = '0;
    alu_b       = '0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Operands are taken before any write-back, so rd==ra/rb sees old data.
        opa_d   = rf_q[ra_idx];
        opb_d   = rf_q[rb_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_opcode = op;
        alu_a      = opa_q;
        alu_b      = opb_q;
        if (is_alu) begin
          res_d    = alu_resultado;
          aflags_d = {alu_C, alu_S, alu_O, alu_Z};
        end
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
        pc_d    = pc_inc;
        case (op)
          OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB: begin
            rf_d[rd_idx] = res_q;
            flags_d      = aflags_q;
          end
          OP_MUL: begin
            // Product only defines sign and zero; C and O are carried over.
            rf_d[rd_idx] = res_q;
            flags_d      = {flags_q[3], aflags_q[2], flags_q[1], aflags_q[0]};
          end
          OP_NOP: ;
          OP_JMP: pc_d = pc_imm;
          OP_JC:  pc_d = flags_q[3] ? pc_imm : pc_inc;
          OP_JS:  pc_d = flags_q[2] ? pc_imm : pc_inc;
          OP_JO:  pc_d = flags_q[1] ? pc_imm : pc_inc;
          OP_JZ:  pc_d = flags_q[0] ? pc_imm : pc_inc;
          OP_HLT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
`ifdef ALU_SEQ_LDI_EN
          OP_LD:  rf_d[rd_idx] = BITS_DATA'(instr_q[14:0]);
`endif
          default: illegal_d = 1'b1;
        endcase
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      aflags_q  <= '0;
      pc_q      <= '0;
      flags_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      aflags_q  <= aflags_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      rf_q      <= rf_d;
    end
  end

  assign pc       = pc_q;
  assign flags    = flags_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign dbg_data = rf_q[IDX_W'(dbg_addr)];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. Provides a behavioural
//               ALU, a table of hand-derived vectors, randomized instruction
//               streams against an architectural reference model, and directed
//               sequences for handshake timing, reset-in-flight and HLT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam logic [4:0] OP_NOP = 5'd0,  OP_NOT = 5'd1,  OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3,  OP_XOR = 5'd4,  OP_NEG = 5'd5;
  localparam logic [4:0] OP_ADD = 5'd6,  OP_SUB = 5'd7,  OP_MUL = 5'd8;
  localparam logic [4:0] OP_DIV = 5'd9,  OP_LD  = 5'd11, OP_JMP = 5'd13;
  localparam logic [4:0] OP_JC  = 5'd14, OP_JS  = 5'd15, OP_JO  = 5'd16;
  localparam logic [4:0] OP_JZ  = 5'd17, OP_HLT = 5'd18;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready;
  logic [31:0] instr;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_resultado, dbg_data;
  logic        alu_C, alu_S, alu_O, alu_Z;
  logic [7:0]  pc;
  logic [3:0]  flags, dbg_addr;
  logic        halted, illegal;

  always #5 clk = ~clk;

  alu_sequencer #(.BITS_DATA(32), .NUM_REGS(16), .PC_BITS(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_resultado(alu_resultado), .alu_C(alu_C), .alu_S(alu_S), .alu_O(alu_O),
    .alu_Z(alu_Z), .pc(pc), .flags(flags), .halted(halted), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: {C,S,O,Z,result}. Non-arithmetic opcodes return junk so
  // that any wrongful latch shows up; MUL returns junk C/O.
  function automatic logic [35:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, o;
    c = 1'b0; o = 1'b0; r = 32'h0;
    case (op)
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NEG: begin r = 32'd0 - a; c = (a != 0); o = (a == 32'h8000_0000); end
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                    o = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; c = (a < b); o = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_MUL: begin r = a * b; c = r[0]; o = ~r[0]; end
      default: return {4'b1111, 32'hDEAD_BEEF};
    endcase
    return {c, r[31], o, (r == 32'd0), r};
  endfunction

  always_comb {alu_C, alu_S, alu_O, alu_Z, alu_resultado} = alu_ref(alu_opcode, alu_a, alu_b);

  // ---------------- architectural reference model ----------------
  logic [31:0] m_rf [16];
  logic [7:0]  m_pc;
  logic [3:0]  m_flags;
  logic        m_ill, m_halt;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_pc = 8'd0; m_flags = 4'd0; m_ill = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] w);
    logic [4:0]  op;
    logic [35:0] x;
    logic [7:0]  tgt;
    op  = w[31:27];
    tgt = w[7:0];
    x   = alu_ref(op, m_rf[w[22:19]], m_rf[w[18:15]]);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB: begin
        m_rf[w[26:23]] = x[31:0]; m_flags = x[35:32]; m_pc = m_pc + 8'd1;
      end
      OP_MUL: begin
        m_rf[w[26:23]] = x[31:0];
        m_flags = {m_flags[3], x[31], m_flags[1], (x[31:0] == 32'd0)};
        m_pc = m_pc + 8'd1;
      end
      OP_NOP: m_pc = m_pc + 8'd1;
      OP_JMP: m_pc = tgt;
      OP_JC:  m_pc = m_flags[3] ? tgt : m_pc + 8'd1;
      OP_JS:  m_pc = m_flags[2] ? tgt : m_pc + 8'd1;
      OP_JO:  m_pc = m_flags[1] ? tgt : m_pc + 8'd1;
      OP_JZ:  m_pc = m_flags[0] ? tgt : m_pc + 8'd1;
      OP_HLT: m_halt = 1'b1;
`ifdef ALU_SEQ_LDI_EN
      OP_LD:  begin m_rf[w[26:23]] = {17'd0, w[14:0]}; m_pc = m_pc + 8'd1; end
`endif
      default: begin m_ill = 1'b1; m_pc = m_pc + 8'd1; end
    endcase
  endtask

  // ---------------- helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input int rd, input int ra, input int rb, input int imm);
    logic [31:0] r, a, b, m;
    r = rd; a = ra; b = rb; m = imm;
    return {op, r[3:0], a[3:0], b[3:0], m[14:0]};
  endfunction

  task automatic read_reg(input int idx, output logic [31:0] v);
    logic [31:0] t;
    t = idx;
    dbg_addr = t[3:0];
    #1;
    v = dbg_data;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after WB.
  task automatic issue(input logic [31:0] w);
    int budget;
    budget = 0;
    while (!instr_ready && budget < 20) begin @(negedge clk); budget++; end
    if (!instr_ready) begin
      check("issue_ready_timeout", {31'd0, instr_ready}, 32'd1);
      return;
    end
    instr_valid = 1'b1; instr = w;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [31:0] w;
    logic [7:0]  pc;
    logic [3:0]  fl;
    logic        ill;
    logic [3:0]  r;
    logic [31:0] v;
  } vec_t;

  localparam int NTBL = 22;
  vec_t tbl [NTBL];

  logic [4:0] legal [14];

  initial begin
    logic [31:0] v;
    logic [31:0] w;
    logic [4:0]  op;
    int          cnt;

    reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // ---- reset state ----
    check("rst_ready",   {31'd0, instr_ready}, 32'd1);
    check("rst_pc",      {24'd0, pc}, 32'd0);
    check("rst_flags",   {28'd0, flags}, 32'd0);
    check("rst_halted",  {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_aluop",   {27'd0, alu_opcode}, {27'd0, OP_NOP});
    check("rst_alua",    alu_a, 32'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin read_reg(i, v); if (v != 0) cnt++; end
    check("rst_rf_nonzero", cnt, 32'd0);
    @(negedge clk);

    // ---- hand-derived vectors: {instr, pc, flags CSOZ, illegal, reg, value} ----
    tbl[0]  = '{enc(OP_NOT, 1, 0, 0, 0),     8'h01, 4'b0100, 1'b0, 4'd1,  32'hFFFF_FFFF};
    tbl[1]  = '{enc(OP_NEG, 2, 1, 0, 0),     8'h02, 4'b1000, 1'b0, 4'd2,  32'd1};
    tbl[2]  = '{enc(OP_ADD, 3, 2, 2, 0),     8'h03, 4'b0000, 1'b0, 4'd3,  32'd2};
    tbl[3]  = '{enc(OP_SUB, 4, 3, 3, 0),     8'h04, 4'b0001, 1'b0, 4'd4,  32'd0};
    tbl[4]  = '{enc(OP_JZ,  0, 0, 0, 16'h10),8'h10, 4'b0001, 1'b0, 4'd4,  32'd0};
    tbl[5]  = '{enc(OP_JC,  0, 0, 0, 16'h20),8'h11, 4'b0001, 1'b0, 4'd3,  32'd2};
    tbl[6]  = '{enc(OP_SUB, 5, 0, 2, 0),     8'h12, 4'b1100, 1'b0, 4'd5,  32'hFFFF_FFFF};
    tbl[7]  = '{enc(OP_MUL, 6, 3, 3, 0),     8'h13, 4'b1000, 1'b0, 4'd6,  32'd4};
    tbl[8]  = '{enc(OP_JC,  0, 0, 0, 5),     8'h05, 4'b1000, 1'b0, 4'd6,  32'd4};
    tbl[9]  = '{enc(OP_XOR, 7, 1, 1, 0),     8'h06, 4'b1000, 1'b1, 4'd7,  32'd0};
    tbl[10] = '{enc(OP_AND, 7, 1, 6, 0),     8'h07, 4'b0000, 1'b1, 4'd7,  32'd4};
    tbl[11] = '{enc(OP_OR,  8, 7, 2, 0),     8'h08, 4'b0000, 1'b1, 4'd8,  32'd5};
    tbl[12] = '{enc(OP_JMP, 0, 0, 0, 16'h7FFF), 8'hFF, 4'b0000, 1'b1, 4'd8, 32'd5};
    tbl[13] = '{enc(OP_NOP, 0, 0, 0, 0),     8'h00, 4'b0000, 1'b1, 4'd0,  32'd0};
    tbl[14] = '{enc(OP_ADD, 10, 1, 2, 0),    8'h01, 4'b1001, 1'b1, 4'd10, 32'd0};
    tbl[15] = '{enc(OP_JS,  0, 0, 0, 16'h33),8'h02, 4'b1001, 1'b1, 4'd2,  32'd1};
    tbl[16] = '{enc(OP_JO,  0, 0, 0, 16'h33),8'h03, 4'b1001, 1'b1, 4'd2,  32'd1};
    tbl[17] = '{enc(OP_MUL, 9, 1, 1, 0),     8'h04, 4'b1000, 1'b1, 4'd9,  32'd1};
    tbl[18] = '{enc(OP_NEG, 11, 0, 0, 0),    8'h05, 4'b0001, 1'b1, 4'd11, 32'd0};
    tbl[19] = '{enc(OP_SUB, 1, 1, 2, 0),     8'h06, 4'b0100, 1'b1, 4'd1,  32'hFFFF_FFFE};
    tbl[20] = '{enc(OP_DIV, 2, 1, 1, 0),     8'h07, 4'b0100, 1'b1, 4'd2,  32'd1};
    tbl[21] = '{enc(5'd31,  2, 1, 1, 0),     8'h08, 4'b0100, 1'b1, 4'd2,  32'd1};

    for (int i = 0; i < NTBL; i++) begin
      issue(tbl[i].w);
      model_step(tbl[i].w);
      check($sformatf("tbl%0d_pc", i),    {24'd0, pc},    {24'd0, tbl[i].pc});
      check($sformatf("tbl%0d_flags", i), {28'd0, flags}, {28'd0, tbl[i].fl});
      check($sformatf("tbl%0d_ill", i),   {31'd0, illegal}, {31'd0, tbl[i].ill});
      read_reg(int'(tbl[i].r), v);
      check($sformatf("tbl%0d_rf", i), v, tbl[i].v);
    end

    // ---- randomized stream against the reference model ----
    legal = '{OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB, OP_MUL,
              OP_NOP, OP_JMP, OP_JC, OP_JS, OP_JO, OP_JZ, OP_LD};
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(0, 31));
      else                           op = legal[$urandom_range(0, 13)];
      if (op == OP_HLT) op = OP_ADD;
      w = enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 32767));
      issue(w);
      model_step(w);
      check($sformatf("rand%0d_pc", i),     {24'd0, pc},      {24'd0, m_pc});
      check($sformatf("rand%0d_flags", i),  {28'd0, flags},   {28'd0, m_flags});
      check($sformatf("rand%0d_ill", i),    {31'd0, illegal}, {31'd0, m_ill});
      check($sformatf("rand%0d_halted", i), {31'd0, halted},  32'd0);
      read_reg(int'(w[26:23]), v);
      check($sformatf("rand%0d_rf", i), v, m_rf[w[26:23]]);
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(i, v);
      check($sformatf("rand_final_rf%0d", i), v, m_rf[i]);
    end
    @(negedge clk);

    // ---- handshake timing, ALU drive window, dbg_data visibility ----
    do_reset();
    issue(enc(OP_NOT, 1, 0, 0, 0)); model_step(enc(OP_NOT, 1, 0, 0, 0));
    issue(enc(OP_NEG, 2, 1, 0, 0)); model_step(enc(OP_NEG, 2, 1, 0, 0));
    check("t_idle_ready", {31'd0, instr_ready}, 32'd1);
    dbg_addr = 4'd3;
    instr_valid = 1'b1; instr = enc(OP_ADD, 3, 2, 2, 0);
    @(negedge clk);                       // READ
    instr_valid = 1'b0;
    check("t_read_ready", {31'd0, instr_ready}, 32'd0);
    check("t_read_aluop", {27'd0, alu_opcode}, {27'd0, OP_NOP});
    check("t_read_alua", alu_a, 32'd0);
    check("t_read_alub", alu_b, 32'd0);
    @(negedge clk);                       // EXEC
    check("t_exec_aluop", {27'd0, alu_opcode}, {27'd0, OP_ADD});
    check("t_exec_alua", alu_a, 32'd1);
    check("t_exec_alub", alu_b, 32'd1);
    check("t_exec_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);                       // WB
    check("t_wb_aluop", {27'd0, alu_opcode}, {27'd0, OP_NOP});
    check("t_wb_dbg_old", dbg_data, 32'd0);
    check("t_wb_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);                       // IDLE again
    model_step(enc(OP_ADD, 3, 2, 2, 0));
    check("t_after_dbg_new", dbg_data, 32'd2);
    check("t_after_ready", {31'd0, instr_ready}, 32'd1);
    check("t_after_pc", {24'd0, pc}, 32'd3);

    // Back-to-back: valid held high for 12 cycles yields exactly 3 accepts.
    cnt = 0;
    instr_valid = 1'b1; instr = enc(OP_NOP, 0, 0, 0, 0);
    repeat (12) begin
      if (instr_ready) cnt++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("t_b2b_accepts", cnt, 32'd3);
    check("t_b2b_pc", {24'd0, pc}, 32'd6);

    // ---- reset while an ADD is in EXEC ----
    issue(enc(OP_SUB, 5, 0, 2, 0));
    check("r_pre_flags", {28'd0, flags}, 32'hC);
    instr_valid = 1'b1; instr = enc(OP_ADD, 4, 2, 2, 0);
    @(negedge clk);                       // READ
    instr_valid = 1'b0;
    @(negedge clk);                       // EXEC
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("r_pc", {24'd0, pc}, 32'd0);
    check("r_flags", {28'd0, flags}, 32'd0);
    check("r_ready", {31'd0, instr_ready}, 32'd1);
    read_reg(4, v); check("r_rf4", v, 32'd0);
    read_reg(3, v); check("r_rf3", v, 32'd0);
    @(negedge clk);

    // ---- LD behaviour with and without the immediate-load option ----
    issue(enc(OP_LD, 1, 0, 0, 5));
    read_reg(1, v);
`ifdef ALU_SEQ_LDI_EN
    check("ld_ill", {31'd0, illegal}, 32'd0);
    check("ld_rf1", v, 32'd5);
    check("ld_pc", {24'd0, pc}, 32'd1);
    @(negedge clk);
    issue(enc(OP_LD, 2, 0, 0, 7));
    issue(enc(OP_ADD, 3, 1, 2, 0));
    read_reg(3, v);
    check("ld_add_rf3", v, 32'd12);
    check("ld_add_flags", {28'd0, flags}, 32'd0);
    check("ld_add_pc", {24'd0, pc}, 32'd3);
`else
    check("ld_ill", {31'd0, illegal}, 32'd1);
    check("ld_rf1", v, 32'd0);
    check("ld_pc", {24'd0, pc}, 32'd1);
`endif
    @(negedge clk);

    // ---- HLT: frozen until reset ----
    do_reset();
    issue(enc(OP_NOP, 0, 0, 0, 0));
    issue(enc(OP_HLT, 0, 0, 0, 0));
    check("h_halted", {31'd0, halted}, 32'd1);
    check("h_pc", {24'd0, pc}, 32'd1);
    instr_valid = 1'b1; instr = enc(OP_NOP, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("h_ready_c%0d", i), {31'd0, instr_ready}, 32'd0);
      check($sformatf("h_pc_c%0d", i), {24'd0, pc}, 32'd1);
      @(negedge clk);
    end
    do_reset();
    check("h_rst_pc", {24'd0, pc}, 32'd0);
    check("h_rst_halted", {31'd0, halted}, 32'd0);
    check("h_rst_ready", {31'd0, instr_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
